// File: rtl/sha256_pkg.sv
// sha256_pkg: state encoding and 512-bit block layout constants shared by the SHA-256 message padder.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        HANDOFF,
        WAITC
    } state_t;

    localparam int         BLOCK_WORDS   = 16;
    localparam logic [7:0] PAD_BYTE      = 8'h80;
    localparam logic [3:0] LEN_HI_IDX    = 4'd14;
    localparam logic [3:0] LEN_LO_IDX    = 4'd15;
    localparam logic [3:0] LAST_WORD_IDX = 4'(BLOCK_WORDS - 1);

    // A block can carry the 64-bit length only if its 0x80 marker sits before the length words.
    function automatic logic carries_len(input logic [3:0] idx);
        return idx < LEN_HI_IDX;
    endfunction

endpackage

// File: rtl/sha256_pad_merge.sv
// sha256_pad_merge: keeps the valid MSB-aligned bytes of a final beat, zeroes the rest and
// drops the 0x80 marker right after the last valid byte when the word is not full.
module sha256_pad_merge
    import sha256_pkg::*;
(
    input  logic [31:0] in_data,
    input  logic [2:0]  in_bytes,
    output logic [31:0] merged,
    output logic [2:0]  eff_bytes,
    output logic        full_word,
    output logic        bytes_err
);

    always_comb begin
        bytes_err = (in_bytes > 3'd4);
        eff_bytes = bytes_err ? 3'd4 : in_bytes;
        full_word = (eff_bytes == 3'd4);
        case (eff_bytes)
            3'd0:    merged = {PAD_BYTE, 24'h000000};
            3'd1:    merged = {in_data[31:24], PAD_BYTE, 16'h0000};
            3'd2:    merged = {in_data[31:16], PAD_BYTE, 8'h00};
            3'd3:    merged = {in_data[31:8], PAD_BYTE};
            default: merged = in_data;
        endcase
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: streams message words into the schedule load port, appends SHA-256 padding and
// hands each 512-bit block to the core. Define SHA256_PAD_ERR_EN to add the sticky pad_err output.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int CNT_W = 61
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic        in_ready,
    input  logic        core_ready,
    input  logic        core_ack,
    output logic [31:0] word_out,
    output logic [3:0]  word_addr,
    output logic        word_we,
    output logic        blk_valid,
    output logic        blk_last,
`ifdef SHA256_PAD_ERR_EN
    output logic        pad_err,
`endif
    output logic        busy
);

    state_t           state_q, state_d;
    state_t           nxt_q, nxt_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend80_q, pend80_d;
    logic             carry_q, carry_d;
    logic             last_q, last_d;
    logic [31:0]      word_out_q, word_out_d;
    logic [3:0]       word_addr_q, word_addr_d;
    logic             word_we_q, word_we_d;
    logic             blk_valid_q, blk_valid_d;
    logic             blk_last_q, blk_last_d;
    logic             err_q, err_d;

    logic [31:0]      merged;
    logic [2:0]       eff_bytes;
    logic [2:0]       beat_bytes;
    logic             full_word;
    logic             bytes_err;
    logic             accept;
    logic             ack;
    logic             idx_at_end;
    logic [CNT_W:0]   cnt_sum;
    logic [63:0]      bit_len;

    sha256_pad_merge u_merge (
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .merged    (merged),
        .eff_bytes (eff_bytes),
        .full_word (full_word),
        .bytes_err (bytes_err)
    );

    assign accept     = (state_q == LOAD) && in_valid;
    assign ack        = (state_q == HANDOFF) && blk_valid_q && core_ack;
    assign idx_at_end = (idx_q == LAST_WORD_IDX);
    assign beat_bytes = in_last ? eff_bytes : 3'd4;
    assign cnt_sum    = {1'b0, cnt_q} + {{(CNT_W-2){1'b0}}, beat_bytes};
    assign bit_len    = 64'({cnt_q, 3'b000});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (core_ready) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (idx_at_end) begin
                        state_d = HANDOFF;
                    end else if (in_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                if (idx_at_end) begin
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                if (ack) begin
                    state_d = last_q ? IDLE : WAITC;
                end
            end
            WAITC: begin
                if (core_ready) begin
                    state_d = nxt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == LOAD);
        busy     = (state_q != IDLE);
    end

    always_comb begin
        nxt_d       = nxt_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pend80_d    = pend80_q;
        carry_d     = carry_q;
        last_d      = last_q;
        word_out_d  = word_out_q;
        word_addr_d = word_addr_q;
        word_we_d   = 1'b0;
        blk_valid_d = 1'b0;
        blk_last_d  = 1'b0;
        err_d       = err_q | (accept & cnt_sum[CNT_W]) | (accept & in_last & bytes_err);

        case (state_q)
            IDLE: begin
                if (core_ready) begin
                    idx_d    = 4'd0;
                    cnt_d    = '0;
                    pend80_d = 1'b0;
                    carry_d  = 1'b0;
                    last_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    word_we_d   = 1'b1;
                    word_addr_d = idx_q;
                    cnt_d       = cnt_sum[CNT_W-1:0];
                    idx_d       = idx_q + 4'd1;
                    last_d      = 1'b0;
                    if (!in_last) begin
                        word_out_d = in_data;
                        nxt_d      = LOAD;
                    end else begin
                        // A full last word defers the marker to the next free slot.
                        word_out_d = merged;
                        pend80_d   = full_word;
                        carry_d    = !full_word && carries_len(idx_q);
                        nxt_d      = PAD;
                    end
                end
            end
            PAD: begin
                word_we_d   = 1'b1;
                word_addr_d = idx_q;
                idx_d       = idx_q + 4'd1;
                if (pend80_q) begin
                    word_out_d = {PAD_BYTE, 24'h000000};
                    pend80_d   = 1'b0;
                    if (carries_len(idx_q)) begin
                        carry_d = 1'b1;
                    end
                end else if (carry_q && idx_q == LEN_HI_IDX) begin
                    word_out_d = bit_len[63:32];
                end else if (carry_q && idx_q == LEN_LO_IDX) begin
                    word_out_d = bit_len[31:0];
                end else begin
                    word_out_d = 32'h0000_0000;
                end
                if (idx_at_end) begin
                    last_d = carry_q;
                    nxt_d  = PAD;
                end
            end
            HANDOFF: begin
                blk_valid_d = 1'b1;
                blk_last_d  = last_q;
                if (ack) begin
                    blk_valid_d = 1'b0;
                    blk_last_d  = 1'b0;
                    idx_d       = 4'd0;
                    // An extra pad block always ends with the length.
                    carry_d     = (nxt_q == PAD);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nxt_q       <= IDLE;
            idx_q       <= 4'd0;
            cnt_q       <= '0;
            pend80_q    <= 1'b0;
            carry_q     <= 1'b0;
            last_q      <= 1'b0;
            word_out_q  <= 32'h0000_0000;
            word_addr_q <= 4'd0;
            word_we_q   <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            nxt_q       <= nxt_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pend80_q    <= pend80_d;
            carry_q     <= carry_d;
            last_q      <= last_d;
            word_out_q  <= word_out_d;
            word_addr_q <= word_addr_d;
            word_we_q   <= word_we_d;
            blk_valid_q <= blk_valid_d;
            blk_last_q  <= blk_last_d;
            err_q       <= err_d;
        end
    end

    assign word_out  = word_out_q;
    assign word_addr = word_addr_q;
    assign word_we   = word_we_q;
    assign blk_valid = blk_valid_q;
    assign blk_last  = blk_last_q;

`ifdef SHA256_PAD_ERR_EN
    assign pad_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: drives random and directed messages into the padder and compares every
// written word and block handshake with a byte-level SHA-256 padding model.
`timescale 1ns/1ps
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic        in_ready;
    logic        core_ready;
    logic        core_ack = 1'b0;
    logic [31:0] word_out;
    logic [3:0]  word_addr;
    logic        word_we;
    logic        blk_valid;
    logic        blk_last;
    logic        busy;
`ifdef SHA256_PAD_ERR_EN
    logic        pad_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned msg[$];
    logic [31:0]  exp_words[$];
    logic [35:0]  wr_q[$];
    logic         blk_lastq[$];
    int           blk_pos_q[$];
    logic         blk_valid_prev = 1'b0;
    int           ack_delay = 0;
    int           hold_cnt = 0;
    bit           fill_rand = 1'b1;

    always #5 clk = ~clk;

    sha256_msg_padder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .in_ready   (in_ready),
        .core_ready (core_ready),
        .core_ack   (core_ack),
        .word_out   (word_out),
        .word_addr  (word_addr),
        .word_we    (word_we),
        .blk_valid  (blk_valid),
        .blk_last   (blk_last),
`ifdef SHA256_PAD_ERR_EN
        .pad_err    (pad_err),
`endif
        .busy       (busy)
    );

    // Record every word write and every rising blk_valid with the write count at that moment.
    always @(negedge clk) begin
        if (!reset_n) begin
            blk_valid_prev = 1'b0;
        end else begin
            if (word_we) wr_q.push_back({word_addr, word_out});
            if (blk_valid && !blk_valid_prev) begin
                blk_lastq.push_back(blk_last);
                blk_pos_q.push_back(wr_q.size());
            end
            blk_valid_prev = blk_valid;
        end
    end

    // Core side: acknowledge a valid block after ack_delay extra cycles.
    always @(negedge clk) begin
        if (!reset_n) begin
            core_ack = 1'b0;
            hold_cnt = 0;
        end else if (core_ack) begin
            core_ack = 1'b0;
        end else if (blk_valid) begin
            if (hold_cnt >= ack_delay) begin
                core_ack = 1'b1;
                hold_cnt = 0;
            end else begin
                hold_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic make_msg(input int n);
        msg.delete();
        for (int k = 0; k < n; k++) msg.push_back(8'($urandom_range(255)));
    endtask

    // Reference padding: message bytes, 0x80, zeros to 56 mod 64, then the 64-bit big-endian bit count.
    task automatic build_expected();
        byte unsigned p[$];
        longint unsigned bits;
        p = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
        exp_words.delete();
        for (int k = 0; k < p.size(); k += 4) exp_words.push_back({p[k], p[k+1], p[k+2], p[k+3]});
    endtask

    task automatic applyStimulus(input bit bad_bytes, input int abort_after, input int gap_pct);
        int n;
        int beats;
        int i;
        int guard;
        int pos;
        bit prev_acc;
        bit prev_last;
        bit last;
        logic [31:0] prev_data;
        logic [3:0]  prev_addr;
        logic [31:0] d;
        logic [2:0]  b;
        byte unsigned bt;
        n = msg.size();
        beats = (n == 0) ? 1 : (n + 3) / 4;
        i = 0;
        guard = 0;
        prev_acc = 1'b0;
        prev_last = 1'b0;
        prev_data = '0;
        prev_addr = '0;
        wr_q.delete();
        blk_lastq.delete();
        blk_pos_q.delete();
        forever begin
            @(negedge clk);
            if (prev_acc) begin
                checkOutput("beat_we_latency", 64'(word_we), 64'd1);
                checkOutput("beat_addr", 64'(word_addr), 64'(prev_addr));
                if (!prev_last) checkOutput("beat_data", 64'(word_out), 64'(prev_data));
            end
            prev_acc = 1'b0;
            if (i >= beats || (abort_after >= 0 && i >= abort_after) || guard > 3000) break;
            guard++;
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                continue;
            end
            d = '0;
            for (int k = 0; k < 4; k++) begin
                pos = 4 * i + k;
                bt = (pos < n) ? msg[pos] : (fill_rand ? 8'($urandom_range(255)) : 8'h00);
                d = {d[23:0], bt};
            end
            last = (i == beats - 1);
            b = last ? 3'(n - 4 * i) : 3'($urandom_range(7));
            if (bad_bytes && last && b == 3'd4) b = 3'(5 + $urandom_range(2));
            in_data = d;
            in_last = last;
            in_bytes = b;
            in_valid = 1'b1;
            prev_acc = in_ready;
            prev_last = last;
            prev_data = d;
            prev_addr = 4'(i);
            if (in_ready) i++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        checkOutput("drive_timeout", 64'(guard <= 3000), 64'd1);
    endtask

    task automatic wait_blk_valid(input int limit);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!blk_valid && g < limit);
        checkOutput("blk_valid_timeout", 64'(blk_valid), 64'd1);
    endtask

    task automatic checkMessage(input string tag);
        int g;
        int nblk;
        int nw;
        g = 0;
        while (busy && g < 2000) begin
            @(negedge clk);
            g++;
        end
        checkOutput({tag, "_idle_timeout"}, 64'(g < 2000), 64'd1);
        nblk = exp_words.size() / 16;
        nw = (wr_q.size() < exp_words.size()) ? wr_q.size() : exp_words.size();
        checkOutput({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_words.size()));
        for (int k = 0; k < nw; k++)
            checkOutput($sformatf("%s_w%0d", tag, k), 64'(wr_q[k]), 64'({4'(k % 16), exp_words[k]}));
        checkOutput({tag, "_nblocks"}, 64'(blk_lastq.size()), 64'(nblk));
        for (int k = 0; k < blk_lastq.size() && k < nblk; k++) begin
            checkOutput($sformatf("%s_blklast%0d", tag, k), 64'(blk_lastq[k]), 64'(k == nblk - 1));
            checkOutput($sformatf("%s_blkpos%0d", tag, k), 64'(blk_pos_q[k]), 64'(16 * (k + 1)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_word_we"}, 64'(word_we), 64'd0);
        checkOutput({tag, "_word_out"}, 64'(word_out), 64'd0);
        checkOutput({tag, "_word_addr"}, 64'(word_addr), 64'd0);
        checkOutput({tag, "_blk_valid"}, 64'(blk_valid), 64'd0);
        checkOutput({tag, "_blk_last"}, 64'(blk_last), 64'd0);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_abc(input string tag);
        msg = '{8'h61, 8'h62, 8'h63};
        fill_rand = 1'b0;
        build_expected();
        applyStimulus(1'b0, -1, 0);
        checkMessage(tag);
        checkOutput({tag, "_w0"}, 64'(wr_q[0][31:0]), 64'h6162_6380);
        checkOutput({tag, "_w15"}, 64'(wr_q[15][31:0]), 64'h0000_0018);
        checkOutput({tag, "_last"}, 64'(blk_lastq[0]), 64'd1);
        fill_rand = 1'b1;
    endtask

    initial begin
        int n0;
        int g;
        int lens[8];
        reset_n = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_bytes = '0;
        core_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        run_abc("abc");

        msg.delete();
        build_expected();
        applyStimulus(1'b0, -1, 0);
        checkMessage("empty");
        checkOutput("empty_w0", 64'(wr_q[0][31:0]), 64'h8000_0000);
        checkOutput("empty_w15", 64'(wr_q[15][31:0]), 64'd0);

        make_msg(56);
        build_expected();
        applyStimulus(1'b0, -1, 10);
        checkMessage("m56");
        checkOutput("m56_w14", 64'(wr_q[14][31:0]), 64'h8000_0000);
        checkOutput("m56_w15", 64'(wr_q[15][31:0]), 64'd0);
        checkOutput("m56_b0last", 64'(blk_lastq[0]), 64'd0);
        checkOutput("m56_w31", 64'(wr_q[31][31:0]), 64'h0000_01C0);

        // 64 bytes with a slow ack and the core briefly not ready for the extra block.
        make_msg(64);
        build_expected();
        ack_delay = 5;
        applyStimulus(1'b0, -1, 0);
        core_ready = 1'b0;
        wait_blk_valid(100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("hold_valid", 64'(blk_valid), 64'd1);
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            checkOutput("hold_we", 64'(word_we), 64'd0);
        end
        g = 0;
        while (blk_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        checkOutput("hold_release", 64'(blk_valid), 64'd0);
        ack_delay = 0;
        n0 = wr_q.size();
        repeat (4) @(negedge clk);
        checkOutput("waitc_no_write", 64'(wr_q.size()), 64'(n0));
        checkOutput("waitc_busy", 64'(busy), 64'd1);
        core_ready = 1'b1;
        checkMessage("m64");
        checkOutput("m64_w16", 64'(wr_q[16][31:0]), 64'h8000_0000);
        checkOutput("m64_w31", 64'(wr_q[31][31:0]), 64'h0000_0200);

        make_msg(20);
        build_expected();
        applyStimulus(1'b1, -1, 0);
        checkMessage("badbytes");

        lens = '{52, 55, 59, 60, 63, 119, 120, 124};
        foreach (lens[j]) begin
            make_msg(lens[j]);
            build_expected();
            ack_delay = $urandom_range(3);
            applyStimulus(1'b0, -1, 20);
            checkMessage($sformatf("len%0d", lens[j]));
        end
        for (int t = 0; t < 10; t++) begin
            make_msg($urandom_range(140));
            build_expected();
            ack_delay = $urandom_range(3);
            applyStimulus(1'($urandom_range(1)), -1, 25);
            checkMessage($sformatf("rnd%0d", t));
        end
        ack_delay = 0;

        make_msg(40);
        build_expected();
        applyStimulus(1'b0, 7, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        reset_n = 1'b1;
        @(negedge clk);
        run_abc("abc_again");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Front-end writer for the message-schedule load port. Accepts a 32-bit big-endian message word stream and applies SHA-256 padding: 0x80 byte, zero fill, 64-bit bit length.
- Writes each 512-bit block as 16 word writes (addr 0..15), then hands the block to the compression core with a valid/ack handshake.
- Sits between the bus/DMA input and the message scheduler plus round controller.

Parameters:
- CNT_W, 61, width of the internal message byte counter. Bit length is {cnt,3'b000} zero-extended to 64 bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_data  in  32  message word; byte 0 is in [31:24]
- in_valid  in  1  in_data valid
- in_last  in  1  final beat of the message
- in_bytes  in  3  valid bytes on a last beat, 0..4, MSB-aligned; ignored when in_last=0 (non-last beats always carry 4 bytes)
- in_ready  out  1  beat accepted when in_valid & in_ready
- core_ready  in  1  core/scheduler can accept a new block
- core_ack  in  1  one-cycle pulse: core has taken the current block
- word_out  out  32  word to the scheduler (message_word_in)
- word_addr  out  4  word index 0..15 (message_word_addr)
- word_we  out  1  write strobe (write_enable_in)
- blk_valid  out  1  block fully written and ready for the core
- blk_last  out  1  qualifies blk_valid: final block of the message
- busy  out  1  not in IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, idx=0, cnt=0, pend80=0. Reset mid-operation discards the partial block and the message; no blk_valid is issued.
- Word outputs are registered. An accepted beat appears on word_out, word_addr and word_we exactly 1 cycle later; word_we is high 1 cycle per write.
- States:
  - IDLE: in_ready=0. Go to LOAD when core_ready=1 (idx=0, cnt=0).
  - LOAD: in_ready=1.
    - Non-last beat: write in_data at idx, cnt+=4, idx++. If idx was 15, go to HANDOFF with blk_last=0 and nxt=LOAD.
    - Last beat with b=in_bytes: keep bytes 0..b-1 and zero the rest. If b<4, put 0x80 at byte b and write the word at idx, next free p=idx+1. If b=4, write the word, set pend80, p=idx+1. cnt+=b. Go to PAD at p.
  - PAD: in_ready=0. One generated write per cycle at idx:
    - pend80 → 0x80000000, then clear pend80.
    - idx 0..13 → 0.
    - idx 14 → len[63:32]; idx 15 → len[31:0], but only when this block carries the length.
    - The block carries the length iff the 0x80 byte landed at a word index ≤13, or pend80 is emitted at index ≤13. Otherwise indexes 14 and 15 are zero and blk_last=0.
    - After the idx-15 write, go to HANDOFF.
    - If p=16 (the last beat filled word 15), skip PAD and go straight to HANDOFF with blk_last=0. An extra block follows.
  - HANDOFF: blk_valid=1 starting the cycle after the addr-15 write, held until core_ack. On core_ack: blk_valid=0, idx=0.
    - If blk_last=1 → IDLE.
    - If more input is pending → WAITC then LOAD.
    - If an extra pad block is pending → WAITC then PAD.
  - WAITC: wait for core_ready=1, then enter the target state.
- core_ack outside HANDOFF is ignored. core_ack in the same cycle blk_valid rises is accepted.
- cnt wraps mod 2^CNT_W.
- busy=1 in all states except IDLE.

Optional Feature:
- SHA256_PAD_ERR_EN defined:
  - Adds output port pad_err (1 bit, reset 0, sticky until reset).
  - Set when a last beat carries in_bytes 5..7, or when cnt wraps. The beat is then treated as in_bytes=4.
- Not defined: no pad_err port, and in_bytes 5..7 are silently treated as 4.

Decomposition:
- Package sha256_pkg: state enum (IDLE, LOAD, PAD, HANDOFF, WAITC), BLOCK_WORDS=16, PAD_BYTE=8'h80, LEN_HI_IDX=14, LEN_LO_IDX=15.
- One natural sub-module, sha256_pad_merge: combinational merge of in_data, in_bytes and the 0x80 insertion.

Test Plan:
- "abc": in_data=0x61626300, in_last=1, in_bytes=3 → w0=0x61626380, w1..w14=0, w15=0x00000018, blk_valid with blk_last=1.
- Empty message: single beat, in_last=1, in_bytes=0 → w0=0x80000000, w15=0, blk_last=1.
- 56 bytes (14 full beats, last beat in_bytes=4) → block 1: w14=0x80000000, w15=0, blk_last=0. Block 2: w0..w13=0, w14=0, w15=0x000001C0, blk_last=1.
- 64 bytes (16 full beats) → block 1 is all data with blk_last=0. Block 2: w0=0x80000000, w15=0x00000200, blk_last=1.
- Hold core_ack low 5 cycles after blk_valid → blk_valid held, in_ready=0, no word_we. Next block's first write only after core_ready=1.
- Pulse reset_n low after 7 accepted beats → all outputs 0 next cycle. A new "abc" message then produces identical words to test 1.
